// File: rtl/bicubic_pkg.sv
// Shared defaults and width helpers for the bicubic filter datapath
// (coefficient generator, multiplier and tap accumulator stages).
package bicubic_pkg;

  localparam int INPUT_WIDTH_DEF = 36;
  localparam int TAPS_DEF        = 4;
  localparam int FRAC_BITS_DEF   = 14;
  localparam int PIX_WIDTH_DEF   = 8;

  function automatic int clog2(input int v);
    int r;
    for (r = 0; (1 << r) < v; r++) begin
    end
    return r;
  endfunction

  // Accumulator width: product width plus headroom for TAPS additions.
  function automatic int acc_width(input int in_w, input int taps);
    return in_w + clog2(taps);
  endfunction

endpackage

// File: rtl/bicubic_round_clamp.sv
// Pipeline stage 2: round-half-up, arithmetic shift and range handling.
// BICUBIC_ACC_SAT_EN selects clamping; otherwise the result wraps.
module bicubic_round_clamp #(
  parameter int ACC_W     = 38,
  parameter int FRAC_BITS = 14,
  parameter int PIX_WIDTH = 8
) (
  input  logic                    i_clk,
  input  logic                    i_reset_n,
  input  logic                    i_valid,
  input  logic signed [ACC_W-1:0] i_sum,
  output logic [PIX_WIDTH-1:0]    o_pixel,
  output logic                    o_valid,
  output logic                    o_sat
);

  // One extra bit so adding the rounding constant cannot overflow.
  localparam int RW = ACC_W + 1;
  localparam logic signed [RW-1:0] HALF = RW'(1) << (FRAC_BITS - 1);

  logic signed [RW-1:0]  biased, rnd;
  logic                  neg, over, oor;
  logic [PIX_WIDTH-1:0]  pix_d, pix_q;
  logic                  vld_d, vld_q, sat_d, sat_q;

  always_comb begin
    biased = {i_sum[ACC_W-1], i_sum} + HALF;
    rnd    = biased >>> FRAC_BITS;
    neg    = rnd[RW-1];
    over   = !neg && (rnd[RW-1:PIX_WIDTH] != '0);
    oor    = neg || over;
`ifdef BICUBIC_ACC_SAT_EN
    if (neg)       pix_d = '0;
    else if (over) pix_d = '1;
    else           pix_d = rnd[PIX_WIDTH-1:0];
`else
    pix_d = rnd[PIX_WIDTH-1:0];
`endif
    if (!i_valid) pix_d = pix_q;
    vld_d = i_valid;
    sat_d = i_valid && oor;
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      pix_q <= '0;
      vld_q <= 1'b0;
      sat_q <= 1'b0;
    end else begin
      pix_q <= pix_d;
      vld_q <= vld_d;
      sat_q <= sat_d;
    end
  end

  assign o_pixel = pix_q;
  assign o_valid = vld_q;
  assign o_sat   = sat_q;

endmodule

// File: rtl/bicubic_tap_accumulator.sv
// Sums TAPS signed products per output pixel, then rounds/shifts to a pixel.
// Optional clamping via BICUBIC_ACC_SAT_EN (handled in bicubic_round_clamp).
module bicubic_tap_accumulator
  import bicubic_pkg::*;
#(
  parameter int INPUT_WIDTH = INPUT_WIDTH_DEF,
  parameter int TAPS        = TAPS_DEF,
  parameter int FRAC_BITS   = FRAC_BITS_DEF,
  parameter int PIX_WIDTH   = PIX_WIDTH_DEF
) (
  input  logic                          i_clk,
  input  logic                          i_reset_n,
  input  logic                          i_valid,
  input  logic signed [INPUT_WIDTH-1:0] i_data,
  input  logic                          i_first,
  output logic [PIX_WIDTH-1:0]          o_pixel,
  output logic                          o_valid,
  output logic                          o_sat,
  output logic                          o_drop
);

  localparam int ACC_W = acc_width(INPUT_WIDTH, TAPS);
  localparam int CNT_W = clog2(TAPS);
  localparam logic [CNT_W-1:0] LAST = CNT_W'(TAPS - 1);

  logic signed [ACC_W-1:0] ext;
  logic signed [ACC_W-1:0] acc_d, acc_q, sum_d, sum_q;
  logic [CNT_W-1:0]        cnt_d, cnt_q;
  logic                    sum_vld_d, sum_vld_q, drop_d, drop_q;

  always_comb begin
    ext       = {{(ACC_W-INPUT_WIDTH){i_data[INPUT_WIDTH-1]}}, i_data};
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    sum_d     = sum_q;
    sum_vld_d = 1'b0;
    drop_d    = 1'b0;
    if (i_valid) begin
      if (cnt_q == '0 || i_first) begin
        // i_first mid-group restarts: the partial sum is thrown away.
        acc_d  = ext;
        cnt_d  = CNT_W'(1);
        drop_d = i_first && (cnt_q != '0);
      end else if (cnt_q == LAST) begin
        sum_d     = acc_q + ext;
        sum_vld_d = 1'b1;
        cnt_d     = '0;
      end else begin
        acc_d = acc_q + ext;
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      acc_q     <= '0;
      cnt_q     <= '0;
      sum_q     <= '0;
      sum_vld_q <= 1'b0;
      drop_q    <= 1'b0;
    end else begin
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      sum_q     <= sum_d;
      sum_vld_q <= sum_vld_d;
      drop_q    <= drop_d;
    end
  end

  bicubic_round_clamp #(
    .ACC_W     (ACC_W),
    .FRAC_BITS (FRAC_BITS),
    .PIX_WIDTH (PIX_WIDTH)
  ) u_round_clamp (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_valid   (sum_vld_q),
    .i_sum     (sum_q),
    .o_pixel   (o_pixel),
    .o_valid   (o_valid),
    .o_sat     (o_sat)
  );

  assign o_drop = drop_q;

endmodule

// File: tb/tb_bicubic_tap_accumulator.sv
// Scoreboard bench for bicubic_tap_accumulator with directed vectors.
// Expected pixels follow BICUBIC_ACC_SAT_EN when it is defined.
module tb_bicubic_tap_accumulator;

`ifdef BICUBIC_ACC_SAT_EN
  localparam int P_HI = 255;
  localparam int P_LO = 0;
`else
  localparam int P_HI = 31;
  localparam int P_LO = 224;
`endif

  logic               i_clk = 1'b0;
  logic               i_reset_n = 1'b0;
  logic               i_valid = 1'b0;
  logic signed [35:0] i_data = '0;
  logic               i_first = 1'b0;
  logic [7:0]         o_pixel;
  logic               o_valid, o_sat, o_drop;

  typedef struct {
    int pix;
    int sat;
    int cyc;
  } exp_t;

  exp_t expq[$];
  int   dropq[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   last_pix = 0;
  exp_t e;
  int   dc;

  bicubic_tap_accumulator dut (
    .i_clk     (i_clk),
    .i_reset_n (i_reset_n),
    .i_valid   (i_valid),
    .i_data    (i_data),
    .i_first   (i_first),
    .o_pixel   (o_pixel),
    .o_valid   (o_valid),
    .o_sat     (o_sat),
    .o_drop    (o_drop)
  );

  always #5 i_clk = ~i_clk;
  always @(posedge i_clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  // Monitor: pops expectations whenever the DUT presents a result or drop.
  always @(negedge i_clk) begin
    if (i_reset_n) begin
      if (o_valid) begin
        if (expq.size() == 0) begin
          chk("unexpected_valid", 1, 0);
        end else begin
          e = expq.pop_front();
          chk("pixel", int'(o_pixel), e.pix);
          chk("sat", int'(o_sat), e.sat);
          chk("latency_cycle", cyc, e.cyc);
          last_pix = e.pix;
        end
      end else if (o_sat) begin
        chk("sat_without_valid", 1, 0);
      end
      if (o_drop) begin
        if (dropq.size() == 0) begin
          chk("unexpected_drop", 1, 0);
        end else begin
          dc = dropq.pop_front();
          chk("drop_cycle", cyc, dc);
        end
      end
    end
  end

  // last: this tap completes a group, result due two cycles later.
  task automatic send(input int d, input bit f, input bit last, input int px,
                      input int st, input bit drp);
    @(posedge i_clk);
    #1;
    i_valid = 1'b1;
    i_data  = 36'(d);
    i_first = f;
    if (last) expq.push_back('{pix: px, sat: st, cyc: cyc + 2});
    if (drp)  dropq.push_back(cyc + 1);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge i_clk);
      #1;
      i_valid = 1'b0;
      i_first = 1'b0;
      i_data  = '0;
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_pixel"}, int'(o_pixel), 0);
    chk({tag, "_valid"}, int'(o_valid), 0);
    chk({tag, "_sat"},   int'(o_sat),   0);
    chk({tag, "_drop"},  int'(o_drop),  0);
  endtask

  initial begin
    repeat (3) @(posedge i_clk);
    @(negedge i_clk);
    chk_reset_outputs("reset");
    @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;

    // Flat 100 group, then two saturating groups back-to-back.
    send(-102400, 1, 0, 0, 0, 0);
    send(921600,  0, 0, 0, 0, 0);
    send(921600,  0, 0, 0, 0, 0);
    send(-102400, 0, 1, 100, 0, 0);
    send(0,       0, 0, 0, 0, 0);
    send(2350080, 0, 0, 0, 0, 0);
    send(2350080, 0, 0, 0, 0, 0);
    send(0,       0, 1, P_HI, 1, 0);
    send(-261120, 0, 0, 0, 0, 0);
    send(0,       0, 0, 0, 0, 0);
    send(0,       0, 0, 0, 0, 0);
    send(-261120, 0, 1, P_LO, 1, 0);

    // Bubbles between taps 2 and 3.
    send(-102400, 0, 0, 0, 0, 0);
    send(921600,  0, 0, 0, 0, 0);
    send(921600,  0, 0, 0, 0, 0);
    idle(3);
    send(-102400, 0, 1, 100, 0, 0);
    idle(5);
    @(negedge i_clk);
    chk("hold_pixel", int'(o_pixel), last_pix);
    chk("hold_valid", int'(o_valid), 0);

    // Partial group of two taps aborted by i_first.
    send(-102400, 1, 0, 0, 0, 0);
    send(921600,  0, 0, 0, 0, 0);
    send(-102400, 1, 0, 0, 0, 1);
    send(921600,  0, 0, 0, 0, 0);
    send(921600,  0, 0, 0, 0, 0);
    send(-102400, 0, 1, 100, 0, 0);
    idle(5);

    // Reset mid-group: no drop, next valid is tap 0.
    send(-102400, 0, 0, 0, 0, 0);
    send(921600,  0, 0, 0, 0, 0);
    idle(1);
    @(negedge i_clk);
    i_reset_n = 1'b0;
    #1;
    chk_reset_outputs("midreset");
    idle(2);
    i_reset_n = 1'b1;
    send(-102400, 0, 0, 0, 0, 0);
    send(921600,  0, 0, 0, 0, 0);
    send(921600,  0, 0, 0, 0, 0);
    send(-102400, 0, 1, 100, 0, 0);
    idle(1);

    for (int i = 0; i < 20 && (expq.size() != 0 || dropq.size() != 0); i++)
      @(posedge i_clk);
    idle(3);
    chk("pending_results", expq.size(), 0);
    chk("pending_drops", dropq.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
